// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one Wishbone classic read
// per instruction and presents the fetched word to IF/ID.
// Ports: clk, reset (async active-low), stall_in, redirect_en/redirect_pc;
// pc_out, instr_out, instr_valid, fetch_busy, fetch_fault; wb_* master.
// Optional macro FETCH_TIMEOUT_EN enables the ack-wait timeout counter.
module if_fetch_unit #(
  parameter logic [31:0] PC_ADDR        = 32'h8000_0000,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic                  fetch_busy,
  output logic                  fetch_fault,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(PC_ADDR);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  cyc_q, cyc_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] redir_al;
  logic [ADDR_WIDTH-1:0] discard_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO = TIMEOUT_CYCLES[7:0];
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       fault_q, fault_d;
`endif

  assign redir_al   = redirect_pc & ~ADDR_WIDTH'(3);
  // A redirect in the ack cycle is newer than any pending one.
  assign discard_pc = redirect_en ? redir_al : tgt_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 8'd1;
    fault_d  = fault_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (redirect_en) begin
          pc_d = redir_al;
        end else begin
          adr_d   = pc_q;
          cyc_d   = 1'b1;
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      REQ: begin
        if (redirect_en) begin
          pend_d = 1'b1;
          tgt_d  = redir_al;
        end
        if (wb_ack_i) begin
          cyc_d = 1'b0;
          if (redirect_en || pend_q) begin
            pc_d    = discard_pc;
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            instr_d  = wb_dat_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_inc == TO) begin
          cyc_d = 1'b0;
          if (redirect_en || pend_q) begin
            pc_d    = discard_pc;
            pend_d  = 1'b0;
            state_d = IDLE;
          end else begin
            instr_d  = '0;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            fault_d  = 1'b1;
            state_d  = HOLD;
          end
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      HOLD: begin
        if (redirect_en) begin
          valid_d = 1'b0;
          pc_d    = redir_al;
          state_d = IDLE;
`ifdef FETCH_TIMEOUT_EN
          fault_d = 1'b0;
`endif
        end else if (!stall_in) begin
          valid_d = 1'b0;
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = IDLE;
`ifdef FETCH_TIMEOUT_EN
          fault_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RST_PC;
      pend_q   <= 1'b0;
      tgt_q    <= RST_PC;
      cyc_q    <= 1'b0;
      adr_q    <= RST_PC;
      pc_out_q <= RST_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign pc_out      = pc_out_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fetch_busy  = !valid_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = 4'hF;
  assign wb_we_o     = 1'b0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, fetch, stall, redirects,
// PC wrap, mid-transaction reset and (with FETCH_TIMEOUT_EN) timeout.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_fault;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int total = 0;
  int bad   = 0;

  if_fetch_unit #(
    .PC_ADDR(32'h8000_0000),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall_in(stall_in),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .pc_out(pc_out),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .fetch_busy(fetch_busy),
    .fetch_fault(fetch_fault),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_cyc: got %b%b want 00", wb_cyc_o, wb_stb_o);
    end
    total++;
    if (wb_adr_o !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rst_adr: got %h want 80000000", wb_adr_o);
    end
    total++;
    if (pc_out !== 32'h8000_0000 || instr_out !== 32'h0) begin
      bad++;
      $display("FAIL rst_out: got %h/%h want 80000000/0", pc_out, instr_out);
    end
    total++;
    if (instr_valid !== 1'b0 || fetch_busy !== 1'b1 || fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags: got v%b b%b f%b want 0 1 0",
               instr_valid, fetch_busy, fetch_fault);
    end
    total++;
    if (wb_sel_o !== 4'hF || wb_we_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_selwe: got %h/%b want F/0", wb_sel_o, wb_we_o);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0000) begin
      bad++;
      $display("FAIL basic_req: got stb%b adr %h want 1 80000000", wb_stb_o, wb_adr_o);
    end
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_wait: got stb%b v%b want 1 0", wb_stb_o, instr_valid);
    end
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0093;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h0000_0093 ||
        pc_out !== 32'h8000_0000) begin
      bad++;
      $display("FAIL basic_hold: got v%b %h %h want 1 00000093 80000000",
               instr_valid, instr_out, pc_out);
    end
    total++;
    if (wb_cyc_o !== 1'b0 || fetch_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_bus: got cyc%b busy%b want 0 0", wb_cyc_o, fetch_busy);
    end
    tick();
    total++;
    if (instr_valid !== 1'b0 || wb_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_accept: got v%b stb%b want 0 0", instr_valid, wb_stb_o);
    end
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0004) begin
      bad++;
      $display("FAIL basic_next: got stb%b %h want 1 80000004", wb_stb_o, wb_adr_o);
    end
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0113;
    tick();
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h0000_0113 ||
          pc_out !== 32'h8000_0004 || wb_stb_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: got v%b %h %h stb%b want 1 00000113 80000004 0",
                 i, instr_valid, instr_out, pc_out, wb_stb_o);
      end
    end
    stall_in = 1'b0;
    tick();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: got v%b want 0", instr_valid);
    end
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0008) begin
      bad++;
      $display("FAIL stall_next: got stb%b %h want 1 80000008", wb_stb_o, wb_adr_o);
    end
  endtask

  task automatic test_redirect_req();
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect_en = 1'b0;
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0008) begin
      bad++;
      $display("FAIL rreq_stable: got stb%b %h want 1 80000008", wb_stb_o, wb_adr_o);
    end
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL rreq_discard: got v%b cyc%b want 0 0", instr_valid, wb_cyc_o);
    end
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0100 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rreq_target: got stb%b %h v%b want 1 80000100 0",
               wb_stb_o, wb_adr_o, instr_valid);
    end
  endtask

  task automatic test_redirect_hold();
    stall_in = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0013;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h8000_0100) begin
      bad++;
      $display("FAIL rhold_pre: got v%b %h want 1 80000100", instr_valid, pc_out);
    end
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_0202;
    tick();
    redirect_en = 1'b0;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rhold_drop: got v%b want 0", instr_valid);
    end
    stall_in = 1'b0;
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0200) begin
      bad++;
      $display("FAIL rhold_align: got stb%b %h want 1 80000200", wb_stb_o, wb_adr_o);
    end
  endtask

  task automatic test_wrap();
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    wb_ack_i    = 1'b1;
    wb_dat_i    = 32'h1234_5678;
    tick();
    redirect_en = 1'b0;
    wb_ack_i    = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap_ackredir: got v%b cyc%b want 0 0", instr_valid, wb_cyc_o);
    end
    tick();
    total++;
    if (wb_adr_o !== 32'hFFFF_FFFC || wb_stb_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_top: got %h stb%b want fffffffc 1", wb_adr_o, wb_stb_o);
    end
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0033;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1 ||
        instr_out !== 32'h0000_0033) begin
      bad++;
      $display("FAIL wrap_hold: got %h v%b %h want fffffffc 1 00000033",
               pc_out, instr_valid, instr_out);
    end
    tick();
    tick();
    total++;
    if (wb_adr_o !== 32'h0000_0000 || wb_stb_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_zero: got %h stb%b want 00000000 1", wb_adr_o, wb_stb_o);
    end
  endtask

  task automatic test_redirect_idle();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0073;
    tick();
    wb_ack_i = 1'b0;
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_0400;
    tick();
    redirect_en = 1'b0;
    total++;
    if (wb_stb_o !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL ridle_stay: got stb%b v%b want 0 0", wb_stb_o, instr_valid);
    end
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0400) begin
      bad++;
      $display("FAIL ridle_target: got stb%b %h want 1 80000400", wb_stb_o, wb_adr_o);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (wb_cyc_o !== 1'b1 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d: got cyc%b v%b want 1 0", i, wb_cyc_o, instr_valid);
      end
    end
    stall_in = 1'b1;
    tick();
    total++;
    if (wb_cyc_o !== 1'b0 || instr_valid !== 1'b1 || instr_out !== 32'h0 ||
        fetch_fault !== 1'b1 || pc_out !== 32'h8000_0400) begin
      bad++;
      $display("FAIL to_fire: got cyc%b v%b %h f%b %h want 0 1 0 1 80000400",
               wb_cyc_o, instr_valid, instr_out, fetch_fault, pc_out);
    end
    stall_in = 1'b0;
    tick();
    total++;
    if (fetch_fault !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_clear: got f%b v%b want 0 0", fetch_fault, instr_valid);
    end
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0404) begin
      bad++;
      $display("FAIL to_next: got stb%b %h want 1 80000404", wb_stb_o, wb_adr_o);
    end
  endtask
`endif

  task automatic test_reset_mid();
    total++;
    if (wb_cyc_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre: got cyc%b want 1", wb_cyc_o);
    end
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_0001;
    reset    = 1'b0;
    #1;
    total++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rmid_bus: got cyc%b stb%b %h want 0 0 80000000",
               wb_cyc_o, wb_stb_o, wb_adr_o);
    end
    total++;
    if (instr_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h8000_0000 ||
        fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL rmid_out: got v%b %h %h f%b want 0 0 80000000 0",
               instr_valid, instr_out, pc_out, fetch_fault);
    end
    tick();
    total++;
    if (instr_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_lateack: got v%b cyc%b want 0 0", instr_valid, wb_cyc_o);
    end
    wb_ack_i = 1'b0;
    reset    = 1'b1;
    tick();
    total++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rmid_restart: got stb%b %h want 1 80000000", wb_stb_o, wb_adr_o);
    end
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0093;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || instr_out !== 32'h0000_0093 ||
        pc_out !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rmid_fetch: got v%b %h %h want 1 00000093 80000000",
               instr_valid, instr_out, pc_out);
    end
  endtask

  initial begin
    reset       = 1'b0;
    stall_in    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    wb_dat_i    = 32'h0;
    wb_ack_i    = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_req();
    test_redirect_hold();
    test_wrap();
    test_redirect_idle();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
